// File: rtl/mult_share_arb_pkg.sv
// Shared widths and helpers for the multiplier-sharing arbiter.
// Operand/product widths, requester-count range and the id-width rule live here.
package mult_share_arb_pkg;

    localparam int MUL_W       = 32;
    localparam int PROD_W      = 64;
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    // Partial-product rows: one per multiplier bit plus the +1 that completes
    // the two's-complement negation of the sign row.
    localparam int NUM_PP     = MUL_W + 1;
    localparam int PP_IDX_W   = 6;
    localparam int RED_LEVELS = 10;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/response bundle between the clients and the shared multiplier.
// The arbiter is the slave; the requesters and result sink together form the master.
interface mult_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ*mult_share_arb_pkg::MUL_W-1:0] req_a;
    logic [NUM_REQ*mult_share_arb_pkg::MUL_W-1:0] req_b;
    logic [NUM_REQ-1:0]                          req_ready;
    logic                                        rsp_valid;
    logic                                        rsp_ready;
    logic [ID_W-1:0]                             rsp_id;
    logic [mult_share_arb_pkg::PROD_W-1:0]       rsp_product;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// Also returns the pointer value to use if this grant is accepted.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] winner,
    output logic [IDW-1:0] next_ptr
);

    always_comb begin
        int   idx_i;
        logic found;
        grant    = '0;
        winner   = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx_i    = 0;
        for (int j = 0; j < N; j++) begin
            idx_i = int'(ptr) + j;
            if (idx_i >= N) idx_i = idx_i - N;
            if (!found && req[IDW'(idx_i)]) begin
                found               = 1'b1;
                grant[IDW'(idx_i)]  = 1'b1;
                winner              = IDW'(idx_i);
                next_ptr            = (idx_i == N - 1) ? '0 : IDW'(idx_i + 1);
            end
        end
    end

endmodule

// File: rtl/wallace.sv
// Combinational signed 32x32 multiplier: carry-save (3:2) reduction of the
// partial-product rows level by level, then one carry-propagate adder.
module wallace
    import mult_share_arb_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] rows [2**PP_IDX_W];

    always_comb begin
        logic [PROD_W-1:0] a_ext, x, y, z;
        int n, q;
        a_ext = {{(PROD_W-MUL_W){a[MUL_W-1]}}, a};
        x = '0;
        y = '0;
        z = '0;
        for (int i = 0; i < 2**PP_IDX_W; i++) rows[i] = '0;
        for (int i = 0; i < MUL_W - 1; i++)
            rows[PP_IDX_W'(i)] = b[i] ? (a_ext << i) : '0;
        // The sign bit of b weighs -2^31: add ~row here and the +1 in the next row.
        rows[PP_IDX_W'(MUL_W-1)] = b[MUL_W-1] ? ~(a_ext << (MUL_W-1)) : '0;
        rows[PP_IDX_W'(MUL_W)]   = PROD_W'(b[MUL_W-1]);
        n = NUM_PP;
        q = 0;
        for (int lvl = 0; lvl < RED_LEVELS; lvl++) begin
            if (n > 2) begin
                q = n / 3;
                for (int g = 0; g < NUM_PP / 3; g++) begin
                    if (g < q) begin
                        x = rows[PP_IDX_W'(3*g)];
                        y = rows[PP_IDX_W'(3*g+1)];
                        z = rows[PP_IDX_W'(3*g+2)];
                        rows[PP_IDX_W'(2*g)]   = x ^ y ^ z;
                        rows[PP_IDX_W'(2*g+1)] = ((x & y) | (x & z) | (y & z)) << 1;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (r < n - 3*q)
                        rows[PP_IDX_W'(2*q+r)] = rows[PP_IDX_W'(3*q+r)];
                end
                n = 2*q + (n - 3*q);
            end
        end
        product = rows[0] + rows[1];
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin share of one wallace multiplier among NUM_REQ clients.
// Two stages: S1 = operands + id, S2 = product + id; valid/ready on both sides.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    mult_share_arb_if.slave   bus,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    logic                s1_v, s2_v;
    logic [MUL_W-1:0]    s1_a, s1_b;
    logic [ID_W-1:0]     s1_id, s2_id;
    logic [PROD_W-1:0]   s1_prod, s2_prod;
    logic [ID_W-1:0]     rr_ptr, winner, next_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [MUL_W-1:0]    op_a, op_b;
    logic                s1_adv, s2_adv, rsp_fire;

    rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
        .req      (bus.req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .winner   (winner),
        .next_ptr (next_ptr)
    );

    wallace u_mul (
        .a       (s1_a),
        .b       (s1_b),
        .product (s1_prod)
    );

    assign s2_adv   = !s2_v || bus.rsp_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign rsp_fire = s2_v && bus.rsp_ready;

    assign bus.req_ready   = rst ? '0 : (grant & {NUM_REQ{s1_adv}});
    assign bus.rsp_valid   = s2_v;
    assign bus.rsp_id      = s2_id;
    assign bus.rsp_product = s2_prod;
    assign busy            = s1_v || s2_v;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_a = bus.req_a[i*MUL_W +: MUL_W];
                op_b = bus.req_b[i*MUL_W +: MUL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_v     <= 1'b0;
            s2_id    <= '0;
            s2_prod  <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            // S2 data is zeroed when it drains with nothing behind it.
            if (s2_adv) begin
                s2_v    <= s1_v;
                s2_id   <= s1_v ? s1_id : '0;
                s2_prod <= s1_v ? s1_prod : '0;
            end
            if (s1_adv) begin
                s1_v  <= |grant;
                s1_a  <= op_a;
                s1_b  <= op_b;
                s1_id <= winner;
            end
            if (s1_adv && |grant) rr_ptr <= next_ptr;
            if (rsp_fire) op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: table of corner products, directed multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_mult_share_arb;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          busy;
    logic [CW-1:0] op_count;

    mult_share_arb_if #(.NUM_REQ(NR), .ID_W(IDW)) bus ();

    mult_share_arb #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    prod;
        int             t;
    } item_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    item_t q[$];
    int    ptr       = 0;
    int    cyc       = 0;
    int    done_cnt  = 0;
    int    issued    = 0;
    int    hs_seen   = 0;
    int    vectors   = 0;
    int    miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
    endtask

    // Reference: a FIFO of accepted ops; an op is visible at the output once
    // it is the oldest and two edges have passed since its handshake.
    task automatic check_model();
        logic [NR-1:0] eg;
        int            w;
        bit            can, exp_valid;
        eg  = '0;
        w   = -1;
        can = (q.size() < 2) || bus.rsp_ready;
        if (can) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (ptr + k) % NR;
                if (w < 0 && bus.req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) eg = NR'(1) << w;
        exp_valid = 1'b0;
        if (q.size() > 0) exp_valid = (cyc - q[0].t) >= 2;
        if ((bus.req_ready & bus.req_valid) != '0) hs_seen++;
        chk("req_ready", 64'(bus.req_ready), 64'(eg));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        if (!exp_valid) chk("idle_product", bus.rsp_product, 64'd0);
        if (exp_valid && bus.rsp_ready) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
            chk("rsp_product", bus.rsp_product, q[0].prod);
            void'(q.pop_front());
            done_cnt++;
        end
        if (w >= 0) begin
            q.push_back('{IDW'(w), ref_mul(bus.req_a[32*w +: 32], bus.req_b[32*w +: 32]), cyc});
            ptr = (w + 1) % NR;
            issued++;
        end
    endtask

    task automatic cyc_step(input logic [NR-1:0] v, input logic rdy);
        bus.req_valid = v;
        bus.rsp_ready = rdy;
        #1;
        check_model();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        #1;
        chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        cyc++;
        #1;
        rst           = 1'b0;
        bus.req_valid = '0;
        q.delete();
        ptr      = 0;
        done_cnt = 0;
        issued   = 0;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_product", bus.rsp_product, 64'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        tbl[6];
        logic [63:0] held_p;
        logic [IDW-1:0] held_id;
        int          hs0, guard;

        tbl[0] = '{0, 32'h0000_0003, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[1] = '{1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[2] = '{2, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        tbl[3] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        tbl[4] = '{0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        tbl[5] = '{2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        do_reset();

        // Single ops: product visible two edges after the handshake.
        for (int e = 0; e < 6; e++) begin
            set_op(tbl[e].id, tbl[e].a, tbl[e].b);
            cyc_step(NR'(1) << tbl[e].id, 1'b1);
            cyc_step('0, 1'b1);
            chk("tbl_valid", 64'(bus.rsp_valid), 64'd1);
            chk("tbl_id", 64'(bus.rsp_id), 64'(tbl[e].id));
            chk("tbl_product", bus.rsp_product, tbl[e].exp);
            cyc_step('0, 1'b1);
        end

        // Fairness: all requesting, sink always ready.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, $urandom, $urandom);
        for (int k = 0; k < 12; k++) begin
            if (k >= 2) begin
                chk("fair_valid", 64'(bus.rsp_valid), 64'd1);
                chk("fair_id", 64'(bus.rsp_id), 64'((k - 2) % NR));
            end
            cyc_step('1, 1'b1);
        end
        for (int k = 0; k < 3; k++) cyc_step('0, 1'b1);

        // Backpressure: three requesters, sink stalled six cycles.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, $urandom, $urandom);
        hs0 = hs_seen;
        for (int k = 0; k < 3; k++) cyc_step(4'b0111, 1'b0);
        held_p  = bus.rsp_product;
        held_id = bus.rsp_id;
        for (int k = 0; k < 3; k++) cyc_step(4'b0111, 1'b0);
        chk("bp_accepted", 64'(hs_seen - hs0), 64'd2);
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        chk("bp_valid_held", 64'(bus.rsp_valid), 64'd1);
        chk("bp_product_held", bus.rsp_product, held_p);
        chk("bp_id_held", 64'(bus.rsp_id), 64'(held_id));
        for (int k = 0; k < 8; k++) cyc_step(4'b0111, 1'b1);
        for (int k = 0; k < 3; k++) cyc_step('0, 1'b1);

        // Reset with both stages full and a nonzero op_count.
        set_op(0, 32'd7, 32'd9);
        for (int k = 0; k < 3; k++) cyc_step(4'b0001, 1'b0);
        chk("full_busy", 64'(busy), 64'd1);
        do_reset();
        set_op(1, 32'd11, 32'hFFFF_FFFE);
        set_op(3, 32'd5, 32'd5);
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b1;
        #1;
        chk("post_rst_grant", 64'(bus.req_ready), 64'h2);
        cyc_step(4'b1010, 1'b1);
        for (int k = 0; k < 4; k++) cyc_step('0, 1'b1);
        chk("post_rst_count", 64'(op_count), 64'd1);

        // Random traffic against the reference model.
        do_reset();
        guard = 0;
        while (issued < 1000 && guard < 20000) begin
            for (int i = 0; i < NR; i++) set_op(i, rand_operand(), rand_operand());
            cyc_step(NR'($urandom), ($urandom_range(0, 3) != 0));
            guard++;
        end
        chk("rand_issued", 64'(issued), 64'd1000);
        for (int k = 0; k < 4; k++) cyc_step('0, 1'b1);
        chk("rand_done", 64'(done_cnt), 64'd1000);
        chk("rand_op_count", 64'(op_count), 64'd1000);
        chk("rand_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
